fetch_if0: RTL and testbench

Instruction-fetch stage that sits directly upstream of the IF/ID field-split register. Holds the program counter, reads a word-addressed instruction memory, and presents one registered 32-bit instruction per cycle with its PC and a valid flag. Handles stall hold, branch/jump redirect with a one-bubble flush, and an out-of-range fetch fault.

---
 rtl/fetch_if0_if.sv | 31 +++
 rtl/fetch_if0.sv | 94 +++++++++
 tb/tb_fetch_if0.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if0_if.sv
// Fetch-stage control and output bundle: redirect/stall/program-load inputs in,
// registered instruction, PC and status out.
interface fetch_if0_if #(
  parameter int ADDR_W = 6
);
  logic              stall_IF0;
  logic              branch_IF0;
  logic [15:0]       brOff_IF0;
  logic              jump_IF0;
  logic [25:0]       jAddr_IF0;
  logic              wrEn_IF0;
  logic [ADDR_W-1:0] wrAddr_IF0;
  logic [31:0]       wrData_IF0;
  logic [31:0]       instOut_IF0;
  logic [31:0]       pcOut_IF0;
  logic [31:0]       pc4Out_IF0;
  logic              validOut_IF0;
  logic              errOut_IF0;

  modport master (
    output stall_IF0, branch_IF0, brOff_IF0, jump_IF0, jAddr_IF0,
           wrEn_IF0, wrAddr_IF0, wrData_IF0,
    input  instOut_IF0, pcOut_IF0, pc4Out_IF0, validOut_IF0, errOut_IF0
  );

  modport slave (
    input  stall_IF0, branch_IF0, brOff_IF0, jump_IF0, jAddr_IF0,
           wrEn_IF0, wrAddr_IF0, wrData_IF0,
    output instOut_IF0, pcOut_IF0, pc4Out_IF0, validOut_IF0, errOut_IF0
  );
endinterface

// File: rtl/fetch_if0.sv
// Instruction fetch stage: PC register, word-addressed instruction memory and
// registered instruction/PC outputs with stall, one-bubble redirect and fault flag.
module fetch_if0 #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clk_IF0,
  input  logic        rst_n_IF0,
  fetch_if0_if.slave  bus_IF0
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic [31:0] mem_q [IMEM_DEPTH];

  logic [31:0] pc_q,    pc_d;
  logic [31:0] inst_q,  inst_d;
  logic [31:0] pcout_q, pcout_d;
  logic [31:0] pc4_q,   pc4_d;
  logic        valid_q, valid_d;
  logic        err_q,   err_d;

  logic          redirect;
  logic [31:0]   jump_tgt;
  logic [31:0]   branch_tgt;
  logic [31:0]   br_off_bytes;
  logic [AW-1:0] fetch_idx;
  logic          in_range;

  assign redirect     = valid_q & (bus_IF0.jump_IF0 | bus_IF0.branch_IF0);
  assign jump_tgt     = {pc4_q[31:28], bus_IF0.jAddr_IF0, 2'b00};
  assign br_off_bytes = {{14{bus_IF0.brOff_IF0[15]}}, bus_IF0.brOff_IF0, 2'b00};
  assign branch_tgt   = pc4_q + br_off_bytes;
  assign fetch_idx    = pc_q[AW+1:2];
  // Depth is a power of two, so every word index bit above the memory size must be clear.
  assign in_range     = (pc_q[31:AW+2] == '0);

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    pcout_d = pcout_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (redirect) begin
      pc_d    = bus_IF0.jump_IF0 ? jump_tgt : branch_tgt;
      inst_d  = NOP_WORD;
      valid_d = 1'b0;
    end else if (!bus_IF0.stall_IF0) begin
      if (in_range) begin
        inst_d  = mem_q[fetch_idx];
        valid_d = 1'b1;
      end else begin
        inst_d  = NOP_WORD;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
      pcout_d = pc_q;
      pc4_d   = pc_q + 32'd4;
      pc_d    = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk_IF0) begin
    if (!rst_n_IF0) begin
      pc_q    <= RESET_PC;
      inst_q  <= NOP_WORD;
      pcout_q <= 32'd0;
      pc4_q   <= 32'd4;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pcout_q <= pcout_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Program load runs even during reset; a same-cycle fetch sees the old word.
  always_ff @(posedge clk_IF0) begin
    if (bus_IF0.wrEn_IF0) begin
      mem_q[bus_IF0.wrAddr_IF0] <= bus_IF0.wrData_IF0;
    end
  end

  assign bus_IF0.instOut_IF0  = inst_q;
  assign bus_IF0.pcOut_IF0    = pcout_q;
  assign bus_IF0.pc4Out_IF0   = pc4_q;
  assign bus_IF0.validOut_IF0 = valid_q;
  assign bus_IF0.errOut_IF0   = err_q;
endmodule

// File: tb/tb_fetch_if0.sv
// Bench for fetch_if0: directed scenarios with constant expectations, then random
// traffic checked against a cycle-level behavioural model of the fetch rules.
module tb_fetch_if0;
  localparam int DEPTH = 64;

  logic clk_IF0 = 1'b0;
  logic rst_n_IF0;
  int   checks = 0;
  int   errors = 0;

  fetch_if0_if #(.ADDR_W(6)) bus ();

  fetch_if0 #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0), .NOP_WORD(32'h0)) dut (
    .clk_IF0  (clk_IF0),
    .rst_n_IF0(rst_n_IF0),
    .bus_IF0  (bus)
  );

  always #5 clk_IF0 = ~clk_IF0;

  // Behavioural model state
  logic [31:0] m_pc, m_inst, m_pcout, m_pc4;
  logic        m_valid, m_err;
  logic [31:0] m_mem [DEPTH];

  task automatic clear_inputs();
    bus.stall_IF0  = 1'b0;
    bus.branch_IF0 = 1'b0;
    bus.brOff_IF0  = 16'h0;
    bus.jump_IF0   = 1'b0;
    bus.jAddr_IF0  = 26'h0;
    bus.wrEn_IF0   = 1'b0;
    bus.wrAddr_IF0 = 6'h0;
    bus.wrData_IF0 = 32'h0;
  endtask

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic step();
    logic [31:0] n_pc, n_inst, n_pcout, n_pc4, off;
    logic        n_valid, n_err;
    n_pc = m_pc; n_inst = m_inst; n_pcout = m_pcout; n_pc4 = m_pc4;
    n_valid = m_valid; n_err = m_err;
    if (!rst_n_IF0) begin
      n_pc = 0; n_inst = 0; n_pcout = 0; n_pc4 = 4; n_valid = 0; n_err = 0;
    end else if (m_valid && (bus.jump_IF0 || bus.branch_IF0)) begin
      off = {{16{bus.brOff_IF0[15]}}, bus.brOff_IF0};
      if (bus.jump_IF0) n_pc = (m_pc4 & 32'hF000_0000) + ({6'd0, bus.jAddr_IF0} * 4);
      else              n_pc = m_pc4 + off * 4;
      n_inst = 0; n_valid = 0;
    end else if (!bus.stall_IF0) begin
      if ((m_pc / 4) < DEPTH) begin
        n_inst = m_mem[m_pc / 4]; n_valid = 1;
      end else begin
        n_inst = 0; n_valid = 0; n_err = 1;
      end
      n_pcout = m_pc; n_pc4 = m_pc + 4; n_pc = m_pc + 4;
    end
    if (bus.wrEn_IF0) m_mem[bus.wrAddr_IF0] = bus.wrData_IF0;
    @(posedge clk_IF0);
    #1;
    m_pc = n_pc; m_inst = n_inst; m_pcout = n_pcout; m_pc4 = n_pc4;
    m_valid = n_valid; m_err = n_err;
  endtask

  task automatic test_reset();
    logic [31:0] prog [4];
    prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0003;
    prog[2] = 32'h0022_1820; prog[3] = 32'h0000_0000;
    rst_n_IF0 = 1'b0;
    clear_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      bus.wrEn_IF0   = 1'b1;
      bus.wrAddr_IF0 = 6'(i);
      bus.wrData_IF0 = (i < 4) ? prog[i] : $urandom;
      step();
    end
    bus.wrEn_IF0 = 1'b0;
    step();
    checks++;
    if (bus.instOut_IF0 !== 32'h0 || bus.pcOut_IF0 !== 32'h0 || bus.pc4Out_IF0 !== 32'h4 ||
        bus.validOut_IF0 !== 1'b0 || bus.errOut_IF0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: inst=%h pc=%h pc4=%h v=%b e=%b, required 0/0/4/0/0",
               bus.instOut_IF0, bus.pcOut_IF0, bus.pc4Out_IF0, bus.validOut_IF0, bus.errOut_IF0);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_inst [3];
    exp_inst[0] = 32'h2001_0005; exp_inst[1] = 32'h2002_0003; exp_inst[2] = 32'h0022_1820;
    rst_n_IF0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.instOut_IF0 !== exp_inst[i] || bus.pcOut_IF0 !== 32'(i * 4) ||
          bus.pc4Out_IF0 !== 32'(i * 4 + 4) || bus.validOut_IF0 !== 1'b1 || bus.errOut_IF0 !== 1'b0) begin
        errors++;
        $display("FAIL sequential[%0d]: inst=%h pc=%h pc4=%h v=%b e=%b, required %h/%h/%h/1/0", i,
                 bus.instOut_IF0, bus.pcOut_IF0, bus.pc4Out_IF0, bus.validOut_IF0, bus.errOut_IF0,
                 exp_inst[i], 32'(i * 4), 32'(i * 4 + 4));
      end
    end
  endtask

  task automatic test_stall();
    bus.stall_IF0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.instOut_IF0 !== 32'h0022_1820 || bus.pcOut_IF0 !== 32'h8 || bus.validOut_IF0 !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: inst=%h pc=%h v=%b, required 00221820/8/1", i,
                 bus.instOut_IF0, bus.pcOut_IF0, bus.validOut_IF0);
      end
    end
    bus.stall_IF0 = 1'b0;
    step();
    checks++;
    if (bus.pcOut_IF0 !== 32'hC || bus.instOut_IF0 !== 32'h0 || bus.validOut_IF0 !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: pc=%h inst=%h v=%b, required c/0/1",
               bus.pcOut_IF0, bus.instOut_IF0, bus.validOut_IF0);
    end
  endtask

  task automatic test_branch();
    bus.branch_IF0 = 1'b1;
    bus.brOff_IF0  = 16'hFFFC;
    step();
    bus.branch_IF0 = 1'b0;
    checks++;
    if (bus.validOut_IF0 !== 1'b0 || bus.instOut_IF0 !== 32'h0 || bus.pcOut_IF0 !== 32'hC) begin
      errors++;
      $display("FAIL branch_bubble: v=%b inst=%h pc=%h, required 0/0/c",
               bus.validOut_IF0, bus.instOut_IF0, bus.pcOut_IF0);
    end
    step();
    checks++;
    if (bus.pcOut_IF0 !== 32'h0 || bus.validOut_IF0 !== 1'b1 || bus.instOut_IF0 !== 32'h2001_0005) begin
      errors++;
      $display("FAIL branch_target: pc=%h v=%b inst=%h, required 0/1/20010005",
               bus.pcOut_IF0, bus.validOut_IF0, bus.instOut_IF0);
    end
  endtask

  task automatic test_jump_priority();
    step();
    bus.jump_IF0   = 1'b1;
    bus.jAddr_IF0  = 26'h000010;
    bus.branch_IF0 = 1'b1;
    bus.brOff_IF0  = 16'h0002;
    bus.stall_IF0  = 1'b1;
    step();
    checks++;
    if (bus.validOut_IF0 !== 1'b0 || bus.pcOut_IF0 !== 32'h4 || bus.instOut_IF0 !== 32'h0) begin
      errors++;
      $display("FAIL jump_bubble: v=%b pc=%h inst=%h, required 0/4/0",
               bus.validOut_IF0, bus.pcOut_IF0, bus.instOut_IF0);
    end
    // Redirect held through the bubble must be ignored.
    bus.stall_IF0 = 1'b0;
    bus.jAddr_IF0 = 26'h000003;
    step();
    clear_inputs();
    checks++;
    if (bus.pcOut_IF0 !== 32'h40 || bus.validOut_IF0 !== 1'b1 || bus.instOut_IF0 !== m_mem[16]) begin
      errors++;
      $display("FAIL jump_target: pc=%h v=%b inst=%h, required 40/1/%h",
               bus.pcOut_IF0, bus.validOut_IF0, bus.instOut_IF0, m_mem[16]);
    end
  endtask

  task automatic test_out_of_range();
    bus.jump_IF0  = 1'b1;
    bus.jAddr_IF0 = 26'h40;
    step();
    bus.jump_IF0 = 1'b0;
    step();
    checks++;
    if (bus.pcOut_IF0 !== 32'h100 || bus.validOut_IF0 !== 1'b0 || bus.instOut_IF0 !== 32'h0 ||
        bus.errOut_IF0 !== 1'b1) begin
      errors++;
      $display("FAIL oor_fault: pc=%h v=%b inst=%h e=%b, required 100/0/0/1",
               bus.pcOut_IF0, bus.validOut_IF0, bus.instOut_IF0, bus.errOut_IF0);
    end
    bus.jump_IF0  = 1'b1;
    bus.jAddr_IF0 = 26'h0;
    step();
    step();
    bus.jump_IF0 = 1'b0;
    checks++;
    if (bus.pcOut_IF0 !== 32'h108 || bus.validOut_IF0 !== 1'b0 || bus.errOut_IF0 !== 1'b1) begin
      errors++;
      $display("FAIL oor_sticky: pc=%h v=%b e=%b, required 108/0/1",
               bus.pcOut_IF0, bus.validOut_IF0, bus.errOut_IF0);
    end
  endtask

  task automatic test_reset_mid_run();
    rst_n_IF0 = 1'b0;
    step();
    rst_n_IF0 = 1'b1;
    checks++;
    if (bus.instOut_IF0 !== 32'h0 || bus.pcOut_IF0 !== 32'h0 || bus.pc4Out_IF0 !== 32'h4 ||
        bus.validOut_IF0 !== 1'b0 || bus.errOut_IF0 !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: inst=%h pc=%h pc4=%h v=%b e=%b, required 0/0/4/0/0",
               bus.instOut_IF0, bus.pcOut_IF0, bus.pc4Out_IF0, bus.validOut_IF0, bus.errOut_IF0);
    end
    step();
    step();
    checks++;
    if (bus.pcOut_IF0 !== 32'h4 || bus.instOut_IF0 !== 32'h2002_0003 || bus.validOut_IF0 !== 1'b1) begin
      errors++;
      $display("FAIL midrun_restart: pc=%h inst=%h v=%b, required 4/20020003/1",
               bus.pcOut_IF0, bus.instOut_IF0, bus.validOut_IF0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      rst_n_IF0      = ($urandom_range(0, 49) != 0);
      bus.stall_IF0  = ($urandom_range(0, 3) == 0);
      bus.jump_IF0   = ($urandom_range(0, 7) == 0);
      bus.jAddr_IF0  = 26'($urandom_range(0, 63));
      bus.branch_IF0 = ($urandom_range(0, 5) == 0);
      bus.brOff_IF0  = 16'($urandom_range(0, 15)) - 16'd4;
      bus.wrEn_IF0   = ($urandom_range(0, 2) == 0);
      bus.wrAddr_IF0 = 6'($urandom_range(0, 63));
      bus.wrData_IF0 = $urandom;
      step();
      checks++;
      if (bus.instOut_IF0 !== m_inst || bus.pcOut_IF0 !== m_pcout || bus.pc4Out_IF0 !== m_pc4 ||
          bus.validOut_IF0 !== m_valid || bus.errOut_IF0 !== m_err) begin
        errors++;
        $display("FAIL random[%0d]: inst=%h pc=%h pc4=%h v=%b e=%b, required %h/%h/%h/%b/%b", i,
                 bus.instOut_IF0, bus.pcOut_IF0, bus.pc4Out_IF0, bus.validOut_IF0, bus.errOut_IF0,
                 m_inst, m_pcout, m_pc4, m_valid, m_err);
      end
    end
    clear_inputs();
    rst_n_IF0 = 1'b1;
  endtask

  initial begin
    m_pc = 0; m_inst = 0; m_pcout = 0; m_pc4 = 4; m_valid = 0; m_err = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    #2;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump_priority();
    test_out_of_range();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
